// File: rtl/top_hex_pkg.sv
// Shared types and constants for the switch-to-hex display block.
// The glyph table is active-high gfedcba; polarity is applied in the top.
package top_hex_pkg;

    typedef enum logic [1:0] {
        MODE_A   = 2'b00,
        MODE_B   = 2'b01,
        MODE_ADD = 2'b10,
        MODE_XOR = 2'b11
    } mode_t;

    // Lowercase b and d keep those glyphs distinct from 8 and 0.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational 4-bit value to active-high seven-segment glyph (bit 0 = a).
module hex7seg_decoder
    import top_hex_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = GLYPH_TABLE[value];
    end

endmodule

// File: rtl/top_hex_display.sv
// Switch mode/operand select, small ALU, hex glyph decode and registered HEX output.
// TOP_HEX_ACTIVE_LOW_EN selects active-low segment drive (board build).
module top_hex_display
    import top_hex_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] SW,
    output logic [6:0] HEX
);

    mode_t            mode;
    logic [3:0]       opa;
    logic [3:0]       opb;
    logic [3:0]       value_p0;
    logic [6:0]       glyph_p0;
    logic [6:0]       seg_p0;
    logic [6:0]       hex_p1;

    assign mode = mode_t'(SW[9:8]);
    assign opb  = SW[7:4];
    assign opa  = SW[3:0];

    always_comb begin
        value_p0 = opa;
        unique case (mode)
            MODE_A:   value_p0 = opa;
            MODE_B:   value_p0 = opb;
            MODE_ADD: value_p0 = opa + opb;  // 4-bit result drops the carry
            MODE_XOR: value_p0 = opa ^ opb;
            default:  value_p0 = opa;
        endcase
    end

    hex7seg_decoder u_decoder (
        .value (value_p0),
        .glyph (glyph_p0)
    );

`ifdef TOP_HEX_ACTIVE_LOW_EN
    localparam logic [6:0] HEX_RESET = ~SEG_OFF;
    assign seg_p0 = ~glyph_p0;
`else
    localparam logic [6:0] HEX_RESET = SEG_OFF;
    assign seg_p0 = glyph_p0;
`endif

    // p0 -> p1: output register isolates the combinational path from the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_p1 <= HEX_RESET;
        end else begin
            hex_p1 <= seg_p0;
        end
    end

    assign HEX = hex_p1;

endmodule

// File: tb/tb_top_hex_display.sv
// Directed self-checking bench for top_hex_display; expectations are written
// for the active-low build and inverted when TOP_HEX_ACTIVE_LOW_EN is undefined.
module tb_top_hex_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] SW;
    logic [6:0] HEX;

    int vectors = 0;
    int miscompares = 0;

    top_hex_display dut (
        .clk (clk),
        .rst (rst),
        .SW  (SW),
        .HEX (HEX)
    );

    always #5 clk = ~clk;

    // Convert a hand-computed active-low value to the polarity of this build.
    function automatic logic [6:0] pol(input logic [6:0] active_low);
`ifdef TOP_HEX_ACTIVE_LOW_EN
        return active_low;
`else
        return ~active_low;
`endif
    endfunction

    task automatic apply(input logic [1:0] mode, input logic [3:0] b, input logic [3:0] a);
        @(negedge clk);
        SW = {mode, b, a};
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        // power-on reset
        #3 rst = 1'b1;
        #1;
        exp = pol(7'h7F);
        vectors++;
        if (HEX !== exp) begin
            $display("FAIL reset_initial: HEX=%h expected=%h", HEX, exp);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        apply(2'b00, 4'h0, 4'hF);
        exp = pol(7'h0E);
        vectors++;
        if (HEX !== exp) begin
            $display("FAIL reset_pre_glyph: HEX=%h expected=%h", HEX, exp);
            miscompares++;
        end
        // mid-run reset between edges must take effect without a clock edge
        @(negedge clk);
        SW = {2'b00, 4'h0, 4'hC};
        #1 rst = 1'b1;
        #1;
        exp = pol(7'h7F);
        vectors++;
        if (HEX !== exp) begin
            $display("FAIL reset_async: HEX=%h expected=%h", HEX, exp);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp = pol(7'h46);
        vectors++;
        if (HEX !== exp) begin
            $display("FAIL reset_release: HEX=%h expected=%h", HEX, exp);
            miscompares++;
        end
    endtask

    task automatic test_mode_a();
        logic [3:0] a_vals [5] = '{4'hC, 4'hF, 4'hD, 4'h6, 4'hE};
        logic [3:0] b_vals [5] = '{4'h3, 4'h9, 4'h0, 4'hF, 4'h5};
        logic [6:0] exps   [5] = '{7'h46, 7'h0E, 7'h21, 7'h02, 7'h06};
        for (int i = 0; i < 5; i++) begin
            apply(2'b00, b_vals[i], a_vals[i]);
            vectors++;
            if (HEX !== pol(exps[i])) begin
                $display("FAIL mode_a[%0d]: HEX=%h expected=%h", i, HEX, pol(exps[i]));
                miscompares++;
            end
        end
    endtask

    task automatic test_mode_b();
        logic [3:0] b_vals [4] = '{4'hC, 4'hF, 4'hD, 4'h6};
        logic [6:0] exps   [4] = '{7'h46, 7'h0E, 7'h21, 7'h02};
        for (int i = 0; i < 4; i++) begin
            apply(2'b01, b_vals[i], 4'hE);
            vectors++;
            if (HEX !== pol(exps[i])) begin
                $display("FAIL mode_b[%0d]: HEX=%h expected=%h", i, HEX, pol(exps[i]));
                miscompares++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            apply(2'b01, 4'h6, 4'(i * 5));
            vectors++;
            if (HEX !== pol(7'h02)) begin
                $display("FAIL mode_b_a_ignored[%0d]: HEX=%h expected=%h", i, HEX, pol(7'h02));
                miscompares++;
            end
        end
    endtask

    task automatic test_add();
        logic [3:0] a_vals [5] = '{4'hC, 4'hF, 4'hD, 4'h6, 4'hE};
        logic [6:0] exps   [5] = '{7'h24, 7'h12, 7'h30, 7'h46, 7'h19};
        for (int i = 0; i < 5; i++) begin
            apply(2'b10, 4'h6, a_vals[i]);
            vectors++;
            if (HEX !== pol(exps[i])) begin
                $display("FAIL add[%0d]: HEX=%h expected=%h", i, HEX, pol(exps[i]));
                miscompares++;
            end
        end
    endtask

    task automatic test_xor();
        logic [3:0] a_vals [5] = '{4'hC, 4'hF, 4'hD, 4'h6, 4'hE};
        logic [6:0] exps   [5] = '{7'h08, 7'h10, 7'h03, 7'h40, 7'h00};
        for (int i = 0; i < 5; i++) begin
            apply(2'b11, 4'h6, a_vals[i]);
            vectors++;
            if (HEX !== pol(exps[i])) begin
                $display("FAIL xor[%0d]: HEX=%h expected=%h", i, HEX, pol(exps[i]));
                miscompares++;
            end
        end
    endtask

    task automatic test_latency();
        // HEX currently shows XOR 6^E = 8 (7'h00 active-low)
        @(negedge clk);
        SW = {2'b00, 4'h0, 4'h1};
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (HEX !== pol(7'h00)) begin
                $display("FAIL latency_hold[%0d]: HEX=%h expected=%h", i, HEX, pol(7'h00));
                miscompares++;
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (HEX !== pol(7'h79)) begin
            $display("FAIL latency_update: HEX=%h expected=%h", HEX, pol(7'h79));
            miscompares++;
        end
        // simultaneous mode and operand change lands together: 3+4=7
        apply(2'b10, 4'h4, 4'h3);
        vectors++;
        if (HEX !== pol(7'h78)) begin
            $display("FAIL latency_mode_and_operand: HEX=%h expected=%h", HEX, pol(7'h78));
            miscompares++;
        end
    endtask

    initial begin
        SW = '0;
        test_reset();
        test_mode_a();
        test_mode_b();
        test_add();
        test_xor();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
